// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer between the control unit and the external multiply
// and divide units. Latches operands, issues a one-cycle start pulse, waits
// CYCLES clocks, then captures the unit result into the architectural HI/LO
// registers and pulses done.
//
// Optional feature: define MULDIV_DIVZERO_EN to short-circuit a divide by
// zero (no divStart, straight to DONE, sticky divZero flag). Without it the
// divZero output is tied low and a zero divisor runs the normal DIV sequence.
module muldiv_seq #(
  parameter int CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        multInit,
  input  logic        divInit,
  input  logic [31:0] value_A,
  input  logic [31:0] value_B,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_low,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_low,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        multStart,
  output logic        divStart,
  output logic        busy,
  output logic        done,
  output logic        divZero,
  output logic [31:0] hi,
  output logic [31:0] low
);

  // Counter is one bit wider than needed to reach CYCLES-1 so it never wraps
  // even though it keeps counting on the capture edge.
  localparam int CW = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_s;
  logic [31:0]     opa_s;
  logic [31:0]     opb_s;
  logic [31:0]     hi_s;
  logic [31:0]     low_s;
  logic            multstart_s;
  logic            divstart_s;
  logic            done_s;
  logic            busy_s;
`ifdef MULDIV_DIVZERO_EN
  logic            divzero_r;
  logic            divzero_s;
`endif

  // Next-state and next-output logic; every output is computed here and
  // registered below so nothing combinational reaches a port.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    opa_s       = opA;
    opb_s       = opB;
    hi_s        = hi;
    low_s       = low;
    multstart_s = 1'b0;
    divstart_s  = 1'b0;
    done_s      = 1'b0;
`ifdef MULDIV_DIVZERO_EN
    divzero_s   = divzero_r;
`endif
    case (state_r)
      IDLE: begin
        if (multInit) begin
          // Multiply wins over a simultaneous divide; the divide is dropped.
          state_s     = MULT;
          count_s     = {CW{1'b0}};
          opa_s       = value_A;
          opb_s       = value_B;
          multstart_s = 1'b1;
`ifdef MULDIV_DIVZERO_EN
          divzero_s   = 1'b0;
`endif
        end else if (divInit) begin
          count_s = {CW{1'b0}};
          opa_s   = value_A;
          opb_s   = value_B;
`ifdef MULDIV_DIVZERO_EN
          if (value_B == 32'd0) begin
            // Zero divisor: skip the divide unit, keep HI/LO, flag it.
            state_s   = DONE;
            done_s    = 1'b1;
            divzero_s = 1'b1;
          end else begin
            state_s    = DIV;
            divstart_s = 1'b1;
            divzero_s  = 1'b0;
          end
`else
          state_s    = DIV;
          divstart_s = 1'b1;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      MULT: begin
        count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        if (count_r == LAST) begin
          hi_s    = mult_hi;
          low_s   = mult_low;
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          state_s = MULT;
        end
      end
      DIV: begin
        count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        if (count_r == LAST) begin
          hi_s    = div_hi;
          low_s   = div_low;
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          state_s = DIV;
        end
      end
      DONE: begin
        // Requests arriving during DONE are deliberately not sampled.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, counter and registered outputs; reset aborts any operation
  // without capturing a result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      count_r   <= {CW{1'b0}};
      opA       <= 32'd0;
      opB       <= 32'd0;
      hi        <= 32'd0;
      low       <= 32'd0;
      multStart <= 1'b0;
      divStart  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      opA       <= opa_s;
      opB       <= opb_s;
      hi        <= hi_s;
      low       <= low_s;
      multStart <= multstart_s;
      divStart  <= divstart_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

`ifdef MULDIV_DIVZERO_EN
  // Sticky divide-by-zero flag, cleared by the next accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divzero_r <= 1'b0;
    end else begin
      divzero_r <= divzero_s;
    end
  end

  assign divZero = divzero_r;
`else
  assign divZero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized
// requests, compared against a plain-arithmetic reference of HI/LO and of
// the request-to-done timing.
module tb_muldiv_seq;

  localparam int CYCLES = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        multInit, divInit;
  logic [31:0] value_A, value_B;
  logic [31:0] mult_hi, mult_low, div_hi, div_low;
  logic [31:0] opA, opB, hi, low;
  logic        multStart, divStart, busy, done, divZero;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_hi, exp_lo;
  logic        exp_dz;

  muldiv_seq #(.CYCLES(CYCLES)) dut (
    .clk(clk), .reset(reset), .multInit(multInit), .divInit(divInit),
    .value_A(value_A), .value_B(value_B),
    .mult_hi(mult_hi), .mult_low(mult_low), .div_hi(div_hi), .div_low(div_low),
    .opA(opA), .opB(opB), .multStart(multStart), .divStart(divStart),
    .busy(busy), .done(done), .divZero(divZero), .hi(hi), .low(low)
  );

  always #5 clk = ~clk;

  // External unit models: results are valid only once the unit has seen
  // CYCLES-1 edges after its init pulse; before that they output junk.
  int unsigned mcnt = 0, dcnt = 0;
  logic [31:0] ma = 32'd0, mb = 32'd0, da = 32'd0, db = 32'd0;
  logic [63:0] mprod;

  always @(posedge clk) begin
    if (multStart) begin
      mcnt <= 1; ma <= opA; mb <= opB;
    end else if (mcnt != 0 && mcnt < 1000) begin
      mcnt <= mcnt + 1;
    end
    if (divStart) begin
      dcnt <= 1; da <= opA; db <= opB;
    end else if (dcnt != 0 && dcnt < 1000) begin
      dcnt <= dcnt + 1;
    end
  end

  assign mprod    = 64'(ma) * 64'(mb);
  assign mult_hi  = (mcnt != 0 && mcnt >= CYCLES-1) ? mprod[63:32] : 32'hBAD0_0BAD;
  assign mult_low = (mcnt != 0 && mcnt >= CYCLES-1) ? mprod[31:0]  : 32'hBAD1_1BAD;
  assign div_hi   = (dcnt != 0 && dcnt >= CYCLES-1) ? ((db == 32'd0) ? da : da % db) : 32'hDEAD_0001;
  assign div_low  = (dcnt != 0 && dcnt >= CYCLES-1) ? ((db == 32'd0) ? 32'hFFFF_FFFF : da / db) : 32'hDEAD_0002;

  // Reference: {HI, LO} of an operation in plain arithmetic.
  function automatic logic [63:0] ref_result(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    if (is_mult) return 64'(a) * 64'(b);
    else if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    else return {a % b, a / b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ops"},   {opA, opB}, 64'd0);
    chk({tag, "_hilo"},  {hi, low}, 64'd0);
    chk({tag, "_flags"}, {multStart, divStart, busy, done, divZero}, 64'd0);
  endtask

  // One request issued in IDLE, followed through to the IDLE after DONE.
  task automatic run_op(input logic mi, input logic di, input logic [31:0] a, input logic [31:0] b);
    logic        acc, dz;
    logic [63:0] res;
    acc = mi | di;
`ifdef MULDIV_DIVZERO_EN
    dz = !mi && di && (b == 32'd0);
`else
    dz = 1'b0;
`endif
    @(negedge clk);
    multInit = mi; divInit = di; value_A = a; value_B = b;
    @(negedge clk);
    multInit = 1'b0; divInit = 1'b0; value_A = $urandom; value_B = $urandom;
    if (!acc) begin
      chk("idle_busy", busy, 0);
      chk("idle_starts", {multStart, divStart}, 0);
      chk("idle_hilo", {hi, low}, {exp_hi, exp_lo});
      chk("idle_divzero", divZero, exp_dz);
      return;
    end
    chk("accept_multstart", multStart, mi);
    chk("accept_divstart", divStart, !mi && di && !dz);
    chk("accept_busy", busy, 1);
    chk("accept_ops", {opA, opB}, {a, b});
    chk("accept_divzero", divZero, dz);
    if (dz) begin
      chk("dz_done", done, 1);
      chk("dz_hilo", {hi, low}, {exp_hi, exp_lo});
    end else begin
      chk("accept_done", done, 0);
      for (int k = 1; k < CYCLES; k++) begin
        multInit = 1'($urandom % 2);
        divInit  = (k == 11) ? 1'b1 : 1'($urandom % 2);
        value_A  = $urandom; value_B = $urandom;
        @(negedge clk);
        chk("run_ctrl", {multStart, divStart, busy, done}, 4'b0010);
        if (k == 16) begin
          chk("run_hilo", {hi, low}, {exp_hi, exp_lo});
          chk("run_ops", {opA, opB}, {a, b});
        end
      end
      @(negedge clk);
      res = ref_result(mi, a, b);
      chk("cap_done", {busy, done}, 2'b11);
      chk("cap_hilo", {hi, low}, res);
      chk("cap_ops", {opA, opB}, {a, b});
      chk("cap_divzero", divZero, 0);
      exp_hi = res[63:32]; exp_lo = res[31:0];
    end
    exp_dz = dz;
    // Requests during DONE must be ignored.
    multInit = 1'b1; divInit = 1'b1;
    @(negedge clk);
    multInit = 1'b0; divInit = 1'b0;
    chk("post_ctrl", {multStart, divStart, busy, done}, 4'b0000);
    chk("post_hilo", {hi, low}, {exp_hi, exp_lo});
    chk("post_divzero", divZero, exp_dz);
  endtask

  initial begin
    reset = 1'b0; multInit = 1'b0; divInit = 1'b0;
    value_A = 32'd0; value_B = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_dz = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // Directed: 7*6, 100/7, simultaneous requests (multiply wins).
    run_op(1'b1, 1'b0, 32'd7, 32'd6);
    chk("mul_7x6", {hi, low}, {32'd0, 32'd42});
    run_op(1'b0, 1'b1, 32'd100, 32'd7);
    chk("div_100_7", {hi, low}, {32'd2, 32'd14});
    run_op(1'b1, 1'b1, 32'd3, 32'd5);
    chk("both_3x5", {hi, low}, {32'd0, 32'd15});
    // Divide by zero: shortcut with the feature, normal sequence without.
    run_op(1'b0, 1'b1, 32'd9, 32'd0);
`ifdef MULDIV_DIVZERO_EN
    chk("div_9_0", {hi, low}, {32'd0, 32'd15});
`else
    chk("div_9_0", {hi, low}, {32'd9, 32'hFFFF_FFFF});
`endif
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Randomized requests.
    for (int i = 0; i < 16; i++) begin
      int unsigned op;
      logic [31:0] a, b;
      op = $urandom % 4;
      a  = $urandom;
      b  = (($urandom % 4) == 0) ? 32'd0 : (($urandom % 2) ? 32'($urandom % 100) : $urandom);
      run_op(op[0], op[1], a, b);
    end

    // Reset in the middle of a divide (counter at 16).
    @(negedge clk);
    divInit = 1'b1; value_A = 32'd1000; value_B = 32'd3;
    @(negedge clk);
    divInit = 1'b0;
    repeat (16) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_dz = 1'b0;
    repeat (CYCLES + 4) @(negedge clk);
    chk_all_zero("after_abort");
    run_op(1'b1, 1'b0, 32'd123456, 32'd789);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
